pong_renderer: RTL and testbench



---
 rtl/pong_pkg.sv | 43 ++++
 rtl/vga_timing.sv | 62 ++++++
 rtl/pong_renderer.sv | 108 ++++++++++
 tb/tb_pong_renderer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - VGA 640x480 raster constants, colour defaults and object geometry type
package pong_pkg;

  localparam int RGB12 = 12;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [RGB12-1:0] DEF_BG_RGB     = 12'h000;
  localparam logic [RGB12-1:0] DEF_BALL_RGB   = 12'hFFF;
  localparam logic [RGB12-1:0] DEF_PADDLE_RGB = 12'h0F0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] width;
    logic [7:0] height;
  } rect_t;

  // 11-bit end coordinates so an object near 1023 cannot wrap back onto the screen.
  function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py, input rect_t r);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, r.x} + {3'b000, r.width};
    y_end = {1'b0, r.y} + {3'b000, r.height};
    return ({1'b0, px} >= {1'b0, r.x}) && ({1'b0, px} < x_end) &&
           ({1'b0, py} >= {1'b0, r.y}) && ({1'b0, py} < y_end);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-enable divider, raster counters, raw sync levels and frame strobes
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pe,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_end,
  output logic       vblank_start
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div <= '0;
    end else if (pe) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign pe     = (div == DIV_LAST);
  assign h_last = (h == 10'(H_TOTAL - 1));
  assign v_last = (v == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (pe) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hsync  = !((h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END)));
  assign vsync  = !((v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END)));
  assign active = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));

  // Strobes qualify with pe so they mark the edge that addresses the named pixel.
  assign frame_end    = pe && h_last && v_last;
  assign vblank_start = pe && h_last && (v == 10'(V_ACTIVE - 1));

endmodule

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - latches ball/paddle geometry per frame and composites registered VGA RGB
module pong_renderer
  import pong_pkg::*;
#(
  parameter int               CLK_DIV    = 4,
  parameter logic [RGB12-1:0] BG_RGB     = DEF_BG_RGB,
  parameter logic [RGB12-1:0] BALL_RGB   = DEF_BALL_RGB,
  parameter logic [RGB12-1:0] PADDLE_RGB = DEF_PADDLE_RGB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ballPosX,
  input  logic [9:0] ballPosY,
  input  logic [7:0] ballWidth,
  input  logic [7:0] ballHeight,
  input  logic [9:0] paddlePosX,
  input  logic [9:0] paddlePosY,
  input  logic [7:0] paddleWidth,
  input  logic [7:0] paddleHeight,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       Hsync,
  output logic       Vsync,
  output logic       frameTick
);

  logic       pe;
  logic [9:0] h;
  logic [9:0] v;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       active;
  logic       frame_end;
  logic       vblank_start;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk          (clk),
    .reset        (reset),
    .pe           (pe),
    .h            (h),
    .v            (v),
    .hsync        (hsync_raw),
    .vsync        (vsync_raw),
    .active       (active),
    .frame_end    (frame_end),
    .vblank_start (vblank_start)
  );

  rect_t ball_q;
  rect_t paddle_q;
  logic  valid;

  // Geometry is sampled only at the very last pixel of a frame, so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ball_q   <= '0;
      paddle_q <= '0;
      valid    <= 1'b0;
    end else if (frame_end) begin
      ball_q   <= '{x: ballPosX, y: ballPosY, width: ballWidth, height: ballHeight};
      paddle_q <= '{x: paddlePosX, y: paddlePosY, width: paddleWidth, height: paddleHeight};
      valid    <= 1'b1;
    end
  end

  logic             in_ball;
  logic             in_paddle;
  logic [RGB12-1:0] pix;
  logic [RGB12-1:0] rgb_q;

  assign in_ball   = valid && in_rect(h, v, ball_q);
  assign in_paddle = valid && in_rect(h, v, paddle_q);

  always_comb begin
    pix = '0;
    if (active) begin
      if (in_ball) begin
        pix = BALL_RGB;
      end else if (in_paddle) begin
        pix = PADDLE_RGB;
      end else begin
        pix = BG_RGB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q     <= '0;
      Hsync     <= 1'b1;
      Vsync     <= 1'b1;
      frameTick <= 1'b0;
    end else begin
      frameTick <= vblank_start;
      if (pe) begin
        rgb_q <= pix;
        Hsync <= hsync_raw;
        Vsync <= vsync_raw;
      end
    end
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - randomized self-checking bench for pong_renderer against a raster model
module tb_pong_renderer;

  localparam int CDIV   = 4;
  localparam int HT     = 800;
  localparam int VT     = 525;
  localparam int FRAME  = HT * VT;
  localparam int BUDGET = 2000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] ballPosX, ballPosY, paddlePosX, paddlePosY;
  logic [7:0] ballWidth, ballHeight, paddleWidth, paddleHeight;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  logic       Hsync, Vsync, frameTick;
  logic [11:0] rgb;

  assign rgb = {vgaRed, vgaGreen, vgaBlue};

  pong_renderer #(.CLK_DIV(CDIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .ballPosX     (ballPosX),
    .ballPosY     (ballPosY),
    .ballWidth    (ballWidth),
    .ballHeight   (ballHeight),
    .paddlePosX   (paddlePosX),
    .paddlePosY   (paddlePosY),
    .paddleWidth  (paddleWidth),
    .paddleHeight (paddleHeight),
    .vgaRed       (vgaRed),
    .vgaGreen     (vgaGreen),
    .vgaBlue      (vgaBlue),
    .Hsync        (Hsync),
    .Vsync        (Vsync),
    .frameTick    (frameTick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e = 0;
  int ticks_seen = 0;
  logic m_valid = 1'b0;
  int mbx = 0, mby = 0, mbw = 0, mbh = 0;
  int mpx = 0, mpy = 0, mpw = 0, mph = 0;

  // Model: e counts clock edges since reset release; pixel n is shown after edge (n+1)*CDIV.
  always @(posedge clk) begin
    if (!reset) begin
      e = 0;
      m_valid = 1'b0;
      mbx = 0; mby = 0; mbw = 0; mbh = 0;
      mpx = 0; mpy = 0; mpw = 0; mph = 0;
    end else begin
      e = e + 1;
      if ((e % CDIV == 0) && ((e / CDIV - 1) % FRAME == FRAME - 1)) begin
        mbx = ballPosX; mby = ballPosY; mbw = ballWidth; mbh = ballHeight;
        mpx = paddlePosX; mpy = paddlePosY; mpw = paddleWidth; mph = paddleHeight;
        m_valid = 1'b1;
      end
    end
  end

  function automatic logic [14:0] model_out();
    int n, hh, vv;
    logic [11:0] c;
    logic hs, vs, tk;
    c = 12'h000; hs = 1'b1; vs = 1'b1; tk = 1'b0;
    if (e >= CDIV) begin
      n  = e / CDIV - 1;
      hh = n % HT;
      vv = (n / HT) % VT;
      hs = !(hh >= 656 && hh < 752);
      vs = !(vv >= 490 && vv < 492);
      tk = (e % CDIV == 0) && (hh == 799) && (vv == 479);
      if (hh < 640 && vv < 480) begin
        if (m_valid && hh >= mbx && hh < mbx + mbw && vv >= mby && vv < mby + mbh)
          c = 12'hFFF;
        else if (m_valid && hh >= mpx && hh < mpx + mpw && vv >= mpy && vv < mpy + mph)
          c = 12'h0F0;
        else
          c = 12'h000;
      end
    end
    return {c, hs, vs, tk};
  endfunction

  always @(negedge clk) begin
    logic [14:0] exp_o;
    exp_o = model_out();
    checks++;
    if ({rgb, Hsync, Vsync, frameTick} !== exp_o) begin
      errors++;
      $display("FAIL cycle e=%0d: got rgb=%h hs=%b vs=%b tick=%b, want rgb=%h hs=%b vs=%b tick=%b",
               e, rgb, Hsync, Vsync, frameTick, exp_o[14:3], exp_o[2], exp_o[1], exp_o[0]);
    end
    if (frameTick === 1'b1) ticks_seen++;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_e(input int target);
    int b;
    b = 0;
    while (e < target && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    if (e != target) begin
      checks++;
      errors++;
      $display("FAIL wait_e: got e=%0d want %0d", e, target);
    end
  endtask

  task automatic wait_pix(input int f, input int hh, input int vv);
    wait_e((f * FRAME + vv * HT + hh + 1) * CDIV);
  endtask

  task automatic pix(input string name, input int f, input int hh, input int vv, input int want);
    wait_pix(f, hh, vv);
    chk(name, int'(rgb), want);
  endtask

  task automatic set_geom(input int bx, input int by, input int bw, input int bh,
                          input int px, input int py, input int pw, input int ph);
    ballPosX = 10'(bx); ballPosY = 10'(by); ballWidth = 8'(bw); ballHeight = 8'(bh);
    paddlePosX = 10'(px); paddlePosY = 10'(py); paddleWidth = 8'(pw); paddleHeight = 8'(ph);
  endtask

  task automatic noise();
    set_geom(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  initial begin : hsync_meas
    int b, lo, per;
    wait (reset === 1'b1);
    b = 0;
    while (Hsync !== 1'b0 && b < 10000) begin @(negedge clk); b++; end
    lo = 0;
    while (Hsync === 1'b0 && lo < 10000) begin @(negedge clk); lo++; end
    per = lo;
    while (Hsync !== 1'b0 && per < 10000) begin @(negedge clk); per++; end
    chk("hsync_low_clks", lo, 96 * CDIV);
    chk("line_period_clks", per, HT * CDIV);
  end

  initial begin : vsync_meas
    int b, lo, per;
    wait (reset === 1'b1);
    b = 0;
    while (Vsync !== 1'b0 && b < BUDGET) begin @(negedge clk); b++; end
    lo = 0;
    while (Vsync === 1'b0 && lo < BUDGET) begin @(negedge clk); lo++; end
    per = lo;
    while (Vsync !== 1'b0 && per < BUDGET) begin @(negedge clk); per++; end
    chk("vsync_low_clks", lo, 2 * HT * CDIV);
    chk("frame_period_clks", per, FRAME * CDIV);
  end

  initial begin : watchdog
    repeat (7000000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1);
  end

  initial begin
    set_geom(100, 50, 20, 20, 90, 60, 80, 20);
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(Hsync), 1);
    chk("reset_vsync", int'(Vsync), 1);
    chk("reset_tick", int'(frameTick), 0);
    reset = 1'b1;

    wait_pix(0, 0, 0);
    chk("first_pix_rgb", int'(rgb), 0);
    chk("first_pix_hsync", int'(Hsync), 1);
    pix("unlatched_ball", 0, 105, 65, 12'h000);
    wait_pix(0, 0, 100); noise();
    wait_pix(0, 0, 300); noise();
    wait_pix(0, 700, 524); set_geom(100, 50, 20, 20, 90, 60, 80, 20);

    pix("ball_left_edge_out", 1, 99, 50, 12'h000);
    pix("ball_top_left", 1, 100, 50, 12'hFFF);
    pix("ball_right_edge_out", 1, 120, 50, 12'h000);
    pix("paddle_only", 1, 95, 65, 12'h0F0);
    pix("ball_over_paddle", 1, 105, 65, 12'hFFF);
    pix("right_of_paddle", 1, 200, 65, 12'h000);
    pix("ball_bottom_right", 1, 119, 69, 12'hFFF);
    wait_pix(1, 0, 200); ballPosX = 10'd300;
    wait_pix(1, 700, 524); set_geom(300, 50, 20, 20, 600, 100, 80, 10);

    pix("old_ball_gone", 2, 100, 50, 12'h000);
    pix("new_ball_x300", 2, 300, 50, 12'hFFF);
    pix("new_ball_br", 2, 319, 69, 12'hFFF);
    pix("new_ball_right_out", 2, 320, 69, 12'h000);
    pix("paddle_left_out", 2, 599, 100, 12'h000);
    pix("paddle_left", 2, 600, 100, 12'h0F0);
    pix("paddle_clipped_out", 2, 650, 100, 12'h000);
    pix("paddle_clip_edge", 2, 639, 109, 12'h0F0);
    wait_pix(2, 0, 200); noise();
    wait_pix(2, 700, 524); noise();
    wait_e(3 * FRAME * CDIV - 1);
    set_geom(1020, int'($urandom_range(0, 400)), 20, int'($urandom_range(1, 60)),
             int'($urandom_range(0, 639)), int'($urandom_range(0, 400)), 0,
             int'($urandom_range(1, 255)));

    wait_pix(3, 0, 300);
    chk("ticks_before_reset", ticks_seen, 3);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_rgb", int'(rgb), 0);
    chk("midreset_hsync", int'(Hsync), 1);
    reset = 1'b1;
    wait_pix(0, 0, 0);
    chk("restart_pix_rgb", int'(rgb), 0);
    wait_pix(0, 655, 0);
    chk("restart_hsync_hi", int'(Hsync), 1);
    wait_pix(0, 656, 0);
    chk("restart_hsync_lo", int'(Hsync), 0);
    wait_pix(0, 0, 2);
    chk("tick_total", ticks_seen, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
